mem_stall_responder: RTL and testbench
======================================

Name: mem_stall_responder

Overview:
- Multi-cycle data-memory responder. It sits on the far side of the memory stage's load/store interface.
- Accepts one read or write request, holds the memory stage off with `stall`, then completes the access after a fixed latency with a one-cycle `done` pulse.
- Replaces the single-cycle memory model so the pipeline's stall path can be exercised.
- Storage is 16-bit words with byte addresses; address bit 0 must be 0.

Parameters:
- ADDR_BITS, 8: number of word-address bits, giving 2^ADDR_BITS words. The word index is addr[ADDR_BITS:1] and upper address bits are ignored, so addresses alias.
- LATENCY, 4: cycles from request acceptance to the `done` pulse. Legal range is 1 to 15.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- addr  in  16  byte address from the memory stage's ALU result
- data_in  in  16  store data (register 2 value)
- rd  in  1  read request
- wr  in  1  write request
- data_out  out  16  read data, valid while done=1 for a read
- done  out  1  one-cycle completion pulse
- stall  out  1  initiator must hold its request and freeze the pipeline
- busy  out  1  a request is in flight (state != IDLE)
- err  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset: synchronous, active-high.
  - All storage words are cleared to 16'h0000.
  - State goes to IDLE, counter to 0, data_out to 16'h0000.
  - done, busy and err are 0 in the cycle after reset.
  - A reset during WAIT aborts the access: no write commits and done is never pulsed.
- States:
  - IDLE: waiting for a request.
  - WAIT: counting latency; the counter is 4 bits.
  - RESP: a single cycle in which done=1.
- Acceptance:
  - In IDLE, with exactly one of rd/wr high and addr[0]=0, the request is latched at the edge: addr word index, data_in, and an op bit.
  - The counter is loaded with LATENCY-1.
  - If LATENCY=1, go straight to RESP; otherwise go to WAIT.
- Illegal request (in IDLE only):
  - Cases: rd&wr both high, or (rd|wr) with addr[0]=1.
  - Result: err=1 for the next cycle, no storage access, state stays IDLE, stall=0.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 1, the next state is RESP.
- RESP:
  - done=1.
  - For a read, data_out = mem[latched index], and it holds that value until the next read's RESP.
  - For a write, mem[latched index] <= latched data at the end of the RESP cycle, and data_out is unchanged.
  - Next state is IDLE. A new request can be accepted in the cycle after RESP, giving back-to-back throughput of one access per LATENCY+1 cycles.
- stall (combinational):
  - stall = (IDLE & legal request present) | WAIT.
  - stall is 0 during RESP, so the pipeline advances in the done cycle.
  - For an access accepted at cycle T: stall is high in cycles T through T+LATENCY-1, and done is high in cycle T+LATENCY.
- Request changes: the inputs are latched, so changes to rd/wr/addr/data_in during WAIT or RESP are ignored.
- Read-after-write: a read to the same word immediately after a write's RESP returns the new data.
- No request (rd=wr=0) in IDLE: outputs stay idle and data_out holds its value.

Test Plan:
- Reset, then read of addr 16'h0010 with LATENCY=4 accepted at cycle T -> stall=1 in cycles T..T+3, done=1 only in cycle T+4, data_out=16'h0000, err=0.
- Write of 16'hBEEF to 16'h0020, then an immediate read of 16'h0020 -> write's done at T+4; read accepted at T+5 with done at T+9 and data_out=16'hBEEF.
- Read with addr=16'h0021 -> err=1 for one cycle, stall=0, done never asserted, no storage change; same result for rd=wr=1 at 16'h0022.
- Aliasing with ADDR_BITS=8: write 16'h1234 to 16'h0004, then read 16'h0204 -> data_out=16'h1234.
- Reset in WAIT: write 16'hAAAA to 16'h0030 and assert rst at T+2 -> no done pulse; a later read of 16'h0030 returns 16'h0000.
- LATENCY=1 build: read accepted at T -> stall=1 only in cycle T, done=1 in T+1. Also, rd held high with changing addr during WAIT still returns data from the originally latched address.

Source files
------------

// File: rtl/mem_stall_responder_if.sv
// Load/store handshake between the memory stage (master) and the
// multi-cycle data-memory responder (slave).
interface mem_stall_responder_if;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        rd;
    logic        wr;
    logic [15:0] data_out;
    logic        done;
    logic        stall;
    logic        busy;
    logic        err;

    modport master (
        output addr, data_in, rd, wr,
        input  data_out, done, stall, busy, err
    );

    modport slave (
        input  addr, data_in, rd, wr,
        output data_out, done, stall, busy, err
    );
endinterface

// File: rtl/mem_stall_responder.sv
// Multi-cycle data-memory responder. Accepts one load or store, holds the
// memory stage off with stall, and completes after LATENCY cycles with a
// single-cycle done pulse. Storage is 16-bit words addressed by byte; the
// word index is addr[ADDR_BITS:1] and higher address bits alias.
module mem_stall_responder #(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_stall_responder_if.slave  bus
);

    localparam int         WORDS    = 2 ** ADDR_BITS;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                 stateQ, stateD;
    logic [3:0]             cntQ, cntD;
    logic                   accept;
    logic [ADDR_BITS-1:0]   idxQ;
    logic [15:0]            wdataQ;
    logic                   opWriteQ;
    logic [15:0]            dataOutQ;
    logic                   errQ;
    logic [15:0]            mem [WORDS];

    logic                   legalReq;
    logic                   illegalReq;
    logic [ADDR_BITS-1:0]   reqIdx;

    assign legalReq   = (bus.rd ^ bus.wr) & ~bus.addr[0];
    assign illegalReq = (bus.rd | bus.wr) & ~legalReq;
    assign reqIdx     = bus.addr[ADDR_BITS:1];

    // Next-state and latency counter: WAIT counts down and hands over to RESP at 1.
    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        accept = 1'b0;
        case (stateQ)
            IDLE: begin
                if (legalReq) begin
                    accept = 1'b1;
                    cntD   = CNT_LOAD;
                    stateD = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cntD = cntQ - 4'd1;
                if (cntQ == 4'd1) begin
                    stateD = RESP;
                end
            end
            RESP: begin
                stateD = IDLE;
            end
            default: begin
                stateD = IDLE;
                cntD   = 4'd0;
            end
        endcase
    end

    // Control state: FSM, counter and the one-cycle illegal-request pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= IDLE;
            cntQ   <= 4'd0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            errQ   <= (stateQ == IDLE) & illegalReq;
        end
    end

    // Request capture at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            idxQ     <= reqIdx;
            wdataQ   <= bus.data_in;
            opWriteQ <= bus.wr;
        end
    end

    // Storage and held read data: stores commit and loads are held at the end of RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++) begin
                mem[i] <= 16'h0000;
            end
            dataOutQ <= 16'h0000;
        end else if (stateQ == RESP) begin
            if (opWriteQ) begin
                mem[idxQ] <= wdataQ;
            end else begin
                dataOutQ <= mem[idxQ];
            end
        end
    end

    // Read data is presented during the done cycle itself, then held.
    assign bus.data_out = (stateQ == RESP && !opWriteQ) ? mem[idxQ] : dataOutQ;
    assign bus.done     = (stateQ == RESP);
    assign bus.busy     = (stateQ != IDLE);
    assign bus.stall    = ((stateQ == IDLE) & legalReq) | (stateQ == WAIT);
    assign bus.err      = errQ;

endmodule

// File: tb/tb_mem_stall_responder.sv
// Bench for mem_stall_responder: one LATENCY=4 and one LATENCY=1 instance,
// a directed vector table, a reset-during-WAIT sequence and randomized
// accesses checked against a word-array reference model.
module tb_mem_stall_responder;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_stall_responder_if busA ();
    mem_stall_responder_if busB ();

    mem_stall_responder #(.ADDR_BITS(8), .LATENCY(LAT_A)) dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA.slave)
    );

    mem_stall_responder #(.ADDR_BITS(8), .LATENCY(LAT_B)) dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB.slave)
    );

    always #5 clk = ~clk;

    int nTests = 0;
    int nFail  = 0;

    logic [15:0] refMem   [2][256];
    logic [15:0] lastRead [2];

    typedef struct {
        int          sel;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        expErr;
        logic [15:0] expOut;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic setIn(input int s, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (s == 0) begin
            busA.rd = r; busA.wr = w; busA.addr = a; busA.data_in = d;
        end else begin
            busB.rd = r; busB.wr = w; busB.addr = a; busB.data_in = d;
        end
    endtask

    function automatic logic [15:0] oData(input int s);
        return (s == 0) ? busA.data_out : busB.data_out;
    endfunction
    function automatic logic oDone(input int s);
        return (s == 0) ? busA.done : busB.done;
    endfunction
    function automatic logic oStall(input int s);
        return (s == 0) ? busA.stall : busB.stall;
    endfunction
    function automatic logic oBusy(input int s);
        return (s == 0) ? busA.busy : busB.busy;
    endfunction
    function automatic logic oErr(input int s);
        return (s == 0) ? busA.err : busB.err;
    endfunction

    task automatic clearModel();
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i++) refMem[s][i] = 16'h0000;
            lastRead[s] = 16'h0000;
        end
    endtask

    // One access from IDLE; called just after a rising edge, returns just after
    // the rising edge that ends the done (or err) cycle.
    task automatic access(input int s, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input bit scramble,
                          output logic [15:0] gotData, output logic gotErr);
        int          lat;
        bit          legal;
        bit          illegal;
        int          idx;
        logic [15:0] expData;
        lat     = (s == 0) ? LAT_A : LAT_B;
        legal   = (r != w) && (a % 2 == 0);
        illegal = (r || w) && !legal;
        idx     = (a / 2) % 256;
        gotData = 16'h0000;
        gotErr  = 1'b0;

        setIn(s, r, w, a, d);
        @(negedge clk);
        chk("req_stall", oStall(s), legal);
        chk("req_done", oDone(s), 1'b0);
        chk("req_err", oErr(s), 1'b0);
        chk("req_busy", oBusy(s), 1'b0);
        @(posedge clk); #1;

        if (legal) begin
            expData = r ? refMem[s][idx] : lastRead[s];
            for (int k = 1; k < lat; k++) begin
                if (scramble) begin
                    setIn(s, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
                end
                @(negedge clk);
                chk("wait_stall", oStall(s), 1'b1);
                chk("wait_done", oDone(s), 1'b0);
                chk("wait_busy", oBusy(s), 1'b1);
                @(posedge clk); #1;
            end
            setIn(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
            chk("resp_done", oDone(s), 1'b1);
            chk("resp_stall", oStall(s), 1'b0);
            chk("resp_busy", oBusy(s), 1'b1);
            chk("resp_data", oData(s), expData);
            gotData = oData(s);
            gotErr  = oErr(s);
            if (w) refMem[s][idx] = d;
            else   lastRead[s]    = expData;
            @(posedge clk); #1;
        end else begin
            setIn(s, 1'b0, 1'b0, 16'h0000, 16'h0000);
            @(negedge clk);
            chk("post_err", oErr(s), illegal);
            chk("post_stall", oStall(s), 1'b0);
            chk("post_done", oDone(s), 1'b0);
            chk("post_busy", oBusy(s), 1'b0);
            chk("post_data", oData(s), lastRead[s]);
            gotData = oData(s);
            gotErr  = oErr(s);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", nTests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] gd;
        logic        ge;
        logic [15:0] ra;

        vecs[0]  = '{0, 1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000};
        vecs[1]  = '{0, 1'b0, 1'b1, 16'h0020, 16'hBEEF, 1'b0, 16'h0000};
        vecs[2]  = '{0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'hBEEF};
        vecs[3]  = '{0, 1'b1, 1'b0, 16'h0021, 16'h0000, 1'b1, 16'hBEEF};
        vecs[4]  = '{0, 1'b1, 1'b1, 16'h0022, 16'h7777, 1'b1, 16'hBEEF};
        vecs[5]  = '{0, 1'b0, 1'b1, 16'h0004, 16'h1234, 1'b0, 16'hBEEF};
        vecs[6]  = '{0, 1'b1, 1'b0, 16'h0204, 16'h0000, 1'b0, 16'h1234};
        vecs[7]  = '{0, 1'b0, 1'b1, 16'h0005, 16'hFFFF, 1'b1, 16'h1234};
        vecs[8]  = '{0, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h1234};
        vecs[9]  = '{1, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0, 16'h0000};
        vecs[10] = '{1, 1'b0, 1'b1, 16'h00FE, 16'h5A5A, 1'b0, 16'h0000};
        vecs[11] = '{1, 1'b1, 1'b0, 16'h02FE, 16'h0000, 1'b0, 16'h5A5A};

        setIn(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        setIn(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        clearModel();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state of both instances
        for (int s = 0; s < 2; s++) begin
            @(negedge clk);
            chk("rst_done", oDone(s), 1'b0);
            chk("rst_busy", oBusy(s), 1'b0);
            chk("rst_err", oErr(s), 1'b0);
            chk("rst_stall", oStall(s), 1'b0);
            chk("rst_data", oData(s), 16'h0000);
            @(posedge clk); #1;
        end

        // Directed vector table, applied back to back
        for (int i = 0; i < 12; i++) begin
            access(vecs[i].sel, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din, 1'b0, gd, ge);
            chk($sformatf("vec%0d_err", i), ge, vecs[i].expErr);
            chk($sformatf("vec%0d_data", i), gd, vecs[i].expOut);
        end

        // Inputs wander during WAIT; the latched address and op must win
        access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b1, gd, ge);
        chk("scramble_data", gd, 16'hBEEF);

        // Idle with no request: outputs idle, data_out held
        repeat (3) begin
            @(negedge clk);
            chk("idle_done", busA.done, 1'b0);
            chk("idle_stall", busA.stall, 1'b0);
            chk("idle_data", busA.data_out, 16'hBEEF);
            @(posedge clk); #1;
        end

        // Reset during WAIT aborts the store
        setIn(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
        @(negedge clk);
        chk("rw_req_stall", busA.stall, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        setIn(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        rst = 1'b1;
        @(negedge clk);
        chk("rw_busy_before", busA.busy, 1'b1);
        chk("rw_done_before", busA.done, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        clearModel();
        repeat (5) begin
            @(negedge clk);
            chk("rw_done_after", busA.done, 1'b0);
            chk("rw_busy_after", busA.busy, 1'b0);
            chk("rw_data_after", busA.data_out, 16'h0000);
            @(posedge clk); #1;
        end
        access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 1'b0, gd, ge);
        chk("rw_readback", gd, 16'h0000);

        // Randomized accesses against the reference model
        for (int n = 0; n < 300; n++) begin
            int s;
            logic r, w;
            s  = int'($urandom_range(0, 1));
            r  = 1'($urandom_range(0, 1));
            w  = 1'($urandom_range(0, 1));
            if (!r && !w) r = 1'b1;
            if (r && w && $urandom_range(0, 3) != 0) w = 1'b0;
            ra = 16'($urandom) & 16'hFE1E;
            if ($urandom_range(0, 7) == 0) ra = ra | 16'h0001;
            access(s, r, w, ra, 16'($urandom), 1'($urandom_range(0, 1)), gd, ge);
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
